// File: rtl/serial_bridge.sv
// serial_bridge
// Device-side endpoint of the processor's memory-mapped serial interface.
//   TX path: bytes written by the datapath go into a small circular FIFO and
//            are sent as 8N1 UART frames on uart_tx_out (LSB first).
//   RX path: a one-byte holding register takes bytes from the host stream and
//            presents them to the datapath until they are consumed.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous, active-low reset
//   cpu_data_in      TX byte from the datapath
//   cpu_wren_in      TX write strobe, one byte per high cycle
//   cpu_ready_out    TX FIFO not full
//   cpu_data_out     RX byte presented to the datapath
//   cpu_valid_out    RX byte pending
//   cpu_rden_in      RX consume strobe
//   host_data_in     RX byte from the host
//   host_valid_in    host byte offered
//   host_ready_out   RX holding register empty
//   uart_tx_out      UART line, idle high, registered
//   tx_idle_out      TX FSM idle and FIFO empty
//   tx_overflow_out  sticky: a write was dropped because the FIFO was full
//   tx_state_out     debug view of the TX FSM state
//
// Handshakes: a host byte transfers on a cycle where host_valid_in and
// host_ready_out are both high; a CPU write is accepted on a cycle where
// cpu_wren_in and cpu_ready_out are both high (otherwise it is dropped and
// flagged); a consume takes effect only while cpu_valid_out is high.

module serial_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_data_in,
  input  logic       cpu_wren_in,
  output logic       cpu_ready_out,
  output logic [7:0] cpu_data_out,
  output logic       cpu_valid_out,
  input  logic       cpu_rden_in,
  input  logic [7:0] host_data_in,
  input  logic       host_valid_in,
  output logic       host_ready_out,
  output logic       uart_tx_out,
  output logic       tx_idle_out,
  output logic       tx_overflow_out,
  output logic [1:0] tx_state_out
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int CPB_M1 = CLKS_PER_BIT - 1;

  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] CLK_LAST = CPB_M1[CW-1:0];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, push, pop;

  logic [1:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic          tx_q, tx_d;

  // Fullness is judged on the registered count, so a write in the same
  // cycle as a pop from a full FIFO is still dropped.
  assign full = (count_q == FULL_CNT);
  assign push = cpu_wren_in && !full;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (cpu_wren_in && full);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= cpu_data_in;
  end

  // ---------------------------------------------------------------------
  // TX FSM. The line is registered from the next-state decode so it
  // changes on the same edge as the state.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
    tx_d      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          clk_cnt_d = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // RX holding register. Consume and capture are mutually exclusive since
  // capture needs the register empty and consume needs it full.
  // ---------------------------------------------------------------------
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (cpu_rden_in && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end else if (host_valid_in && !rx_valid_q) begin
      rx_valid_d = 1'b1;
      rx_data_d  = host_data_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      clk_cnt_q  <= '0;
      tx_q       <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      clk_cnt_q  <= clk_cnt_d;
      tx_q       <= tx_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign cpu_ready_out   = !full;
  assign cpu_data_out    = rx_data_q;
  assign cpu_valid_out   = rx_valid_q;
  assign host_ready_out  = !rx_valid_q;
  assign uart_tx_out     = tx_q;
  assign tx_idle_out     = (state_q == S_IDLE) && (count_q == '0);
  assign tx_overflow_out = ovf_q;
  assign tx_state_out    = state_q;

endmodule

// File: tb/tb_serial_bridge.sv
// Bench for serial_bridge with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Table-driven RX vectors plus hand-written TX, overflow and reset sequences.

module tb_serial_bridge;

  localparam int CPB = 4;

  logic       clock;
  logic       reset;
  logic [7:0] cpu_data_in;
  logic       cpu_wren_in;
  logic       cpu_ready_out;
  logic [7:0] cpu_data_out;
  logic       cpu_valid_out;
  logic       cpu_rden_in;
  logic [7:0] host_data_in;
  logic       host_valid_in;
  logic       host_ready_out;
  logic       uart_tx_out;
  logic       tx_idle_out;
  logic       tx_overflow_out;
  logic [1:0] tx_state_out;

  int n_checks = 0;
  int n_pass   = 0;

  serial_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_data_in     (cpu_data_in),
    .cpu_wren_in     (cpu_wren_in),
    .cpu_ready_out   (cpu_ready_out),
    .cpu_data_out    (cpu_data_out),
    .cpu_valid_out   (cpu_valid_out),
    .cpu_rden_in     (cpu_rden_in),
    .host_data_in    (host_data_in),
    .host_valid_in   (host_valid_in),
    .host_ready_out  (host_ready_out),
    .uart_tx_out     (uart_tx_out),
    .tx_idle_out     (tx_idle_out),
    .tx_overflow_out (tx_overflow_out),
    .tx_state_out    (tx_state_out)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       hv;
    logic [7:0] hd;
    logic       rd;
    logic       ev;
    logic [7:0] ed;
    logic       er;
  } rx_vec_t;

  rx_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called while the first START cycle is visible; checks all 40 frame cycles.
  task automatic tx_frame(input logic [7:0] b, input string name);
    int   bad;
    int   p;
    logic e;
    logic [7:0] bb;
    bad = 0;
    bb  = b;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i != 0) tick();
      p = i / CPB;
      if (p == 0)      e = 1'b0;
      else if (p == 9) e = 1'b1;
      else             e = bb[p-1];
      if (uart_tx_out !== e) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    int bad;

    vecs[0] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[1] = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[2] = '{1'b1, 8'h7E, 1'b1, 1'b0, 8'h3C, 1'b1};
    vecs[3] = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h7E, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h7E, 1'b1};
    vecs[6] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0};
    vecs[8] = '{1'b1, 8'hAA, 1'b1, 1'b0, 8'h55, 1'b1};
    vecs[9] = '{1'b1, 8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0};

    cpu_data_in   = 8'h00;
    cpu_wren_in   = 1'b0;
    cpu_rden_in   = 1'b0;
    host_data_in  = 8'h00;
    host_valid_in = 1'b0;
    reset         = 1'b1;
    #1 reset = 1'b0;
    tick();

    // ---- reset values
    check("rst_uart_tx", uart_tx_out, 1);
    check("rst_cpu_ready", cpu_ready_out, 1);
    check("rst_cpu_valid", cpu_valid_out, 0);
    check("rst_cpu_data", cpu_data_out, 0);
    check("rst_host_ready", host_ready_out, 1);
    check("rst_tx_idle", tx_idle_out, 1);
    check("rst_overflow", tx_overflow_out, 0);
    #2 reset = 1'b1;

    bad = 0;
    repeat (100) begin
      tick();
      if (uart_tx_out !== 1'b1) bad++;
    end
    check("idle_line_100", bad, 0);

    // ---- single byte 0xA5
    cpu_data_in = 8'hA5;
    cpu_wren_in = 1'b1;
    tick();                       // edge N
    cpu_wren_in = 1'b0;
    check("a5_line_at_n", uart_tx_out, 1);
    check("a5_not_idle", tx_idle_out, 0);
    tick();                       // edge N+1: start bit
    tx_frame(8'hA5, "a5_frame");
    tick();
    check("a5_line_after", uart_tx_out, 1);
    check("a5_idle_after", tx_idle_out, 1);

    // ---- burst of five plus one dropped write
    cpu_data_in = 8'h01;
    cpu_wren_in = 1'b1;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          tick();
          if (k == 5) begin
            check("burst_full_ready", cpu_ready_out, 0);
            check("burst_no_ovf_yet", tx_overflow_out, 0);
          end
          if (k == 6) begin
            check("burst_ovf_set", tx_overflow_out, 1);
            check("burst_still_full", cpu_ready_out, 0);
            cpu_wren_in = 1'b0;
          end
          cpu_data_in = 8'(k + 1);
        end
      end
      begin
        tick();
        tick();
        tx_frame(8'h01, "burst_frame_01");
        for (int b = 2; b <= 5; b++) begin
          tick();
          check($sformatf("burst_gap_%0d", b), uart_tx_out, 1);
          tick();
          tx_frame(8'(b), $sformatf("burst_frame_%0d", b));
        end
      end
    join
    tick();
    check("burst_idle_after", tx_idle_out, 1);
    bad = 0;
    repeat (50) begin
      tick();
      if (uart_tx_out !== 1'b1) bad++;
    end
    check("burst_no_sixth_frame", bad, 0);
    check("burst_ovf_sticky", tx_overflow_out, 1);

    // ---- RX holding register table
    for (int i = 0; i < 10; i++) begin
      host_valid_in = vecs[i].hv;
      host_data_in  = vecs[i].hd;
      cpu_rden_in   = vecs[i].rd;
      tick();
      check($sformatf("rx_valid_%0d", i), cpu_valid_out, vecs[i].ev);
      check($sformatf("rx_data_%0d", i), cpu_data_out, vecs[i].ed);
      check($sformatf("rx_host_ready_%0d", i), host_ready_out, vecs[i].er);
    end
    host_valid_in = 1'b0;
    cpu_rden_in   = 1'b0;

    // ---- reset during DATA bit 3 of 0xF0 with more bytes queued
    cpu_wren_in = 1'b1;
    cpu_data_in = 8'hF0;
    tick();                       // edge N
    cpu_data_in = 8'h11;
    tick();
    cpu_data_in = 8'h22;
    tick();
    cpu_data_in = 8'h33;
    tick();                       // edge N+3
    cpu_wren_in = 1'b0;
    repeat (15) tick();           // edge N+18, inside bit 3
    check("mid_bit3_low", uart_tx_out, 0);
    check("mid_not_idle", tx_idle_out, 0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_line_high", uart_tx_out, 1);
    check("mid_rst_idle", tx_idle_out, 1);
    check("mid_rst_ready", cpu_ready_out, 1);
    check("mid_rst_ovf_clear", tx_overflow_out, 0);
    check("mid_rst_rx_valid", cpu_valid_out, 0);
    check("mid_rst_rx_data", cpu_data_out, 0);
    tick();
    #2 reset = 1'b1;
    bad = 0;
    repeat (60) begin
      tick();
      if (uart_tx_out !== 1'b1 || tx_idle_out !== 1'b1) bad++;
    end
    check("post_rst_no_frame", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_bridge.md
# serial_bridge

Device-side endpoint of the processor's memory-mapped serial interface. It accepts bytes the datapath writes (`serial_out`/`serial_wren_out`), buffers them in a small FIFO and serialises them as 8N1 UART on one pin. In the other direction it holds one byte from a host byte stream and presents it on `serial_in`/`serial_valid_in` until the datapath consumes it with `serial_rden_out`. `cpu_ready_out` drives the datapath's `serial_ready_in`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit; legal range ≥2.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, ≥2.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_data_in`  in  8  TX byte from the datapath `serial_out`.
- `cpu_wren_in`  in  1  TX write strobe from `serial_wren_out`; one byte per high cycle.
- `cpu_ready_out`  out  1  TX FIFO not full; drives `serial_ready_in`.
- `cpu_data_out`  out  8  RX byte; drives `serial_in`.
- `cpu_valid_out`  out  1  RX byte pending; drives `serial_valid_in`.
- `cpu_rden_in`  in  1  RX consume strobe from `serial_rden_out`.
- `host_data_in`  in  8  RX byte from the host side.
- `host_valid_in`  in  1  host byte offered.
- `host_ready_out`  out  1  RX holding register empty.
- `uart_tx_out`  out  1  UART line, idle high; registered.
- `tx_idle_out`  out  1  TX FSM in IDLE and FIFO empty.
- `tx_overflow_out`  out  1  sticky flag: a write was dropped because the FIFO was full.

## Operation
- **Reset values:** FIFO empty, FSM IDLE, `uart_tx_out`=1, `cpu_ready_out`=1, `cpu_valid_out`=0, `cpu_data_out`=0, `host_ready_out`=1, `tx_idle_out`=1, `tx_overflow_out`=0. Reset asserted mid-frame aborts the frame at once; the line returns high and FIFO contents are discarded.
- **TX FIFO:**
  - Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - `cpu_ready_out` = (count != FIFO_DEPTH), combinational from count.
  - A write with count==FIFO_DEPTH is dropped and sets `tx_overflow_out`. This holds even if a pop happens in the same cycle; fullness is judged on the pre-edge count.
  - A write and a pop in the same cycle (not full) leave the count unchanged.
- **TX FSM, states IDLE, START, DATA, STOP:**
  - **IDLE:** when count>0, pop the head into an 8-bit shift register and go to START. The bit counter and cycle counter clear.
  - **START:** line 0 for CLKS_PER_BIT cycles, then go to DATA.
  - **DATA:** 8 bits LSB-first, each held CLKS_PER_BIT cycles. Shift right after each bit; go to STOP after bit 7.
  - **STOP:** line 1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Frames are separated by exactly one IDLE cycle when the FIFO is non-empty.
  - `uart_tx_out` is registered from the next-state value, so the line changes on the same edge the state changes.
- **RX holding register:**
  - `host_ready_out` = !`cpu_valid_out`.
  - `host_valid_in` && `host_ready_out` captures `host_data_in` into `cpu_data_out` and sets `cpu_valid_out`.
  - `cpu_rden_in` && `cpu_valid_out` clears `cpu_valid_out`. `cpu_data_out` keeps the last byte.
  - `cpu_rden_in` while not valid is ignored.
  - A host byte offered in the same cycle as a consume is not accepted, because `host_ready_out` is 0. It is accepted on the following cycle if still offered.

## Timing
- Write sampled at edge N into an empty FIFO in IDLE: the pop happens in the cycle after edge N. `uart_tx_out` falls at edge N+1.
- Frame length: 10×CLKS_PER_BIT cycles. The next frame's start bit begins 1 cycle after the stop bit ends.
- RX latency: host handshake at edge M → `cpu_valid_out`=1 after edge M. Consume at edge K → `cpu_valid_out`=0 and `host_ready_out`=1 after edge K.
- `tx_overflow_out` rises after the edge of the dropped write. It clears only on reset.

## Test plan
- Reset, CLKS_PER_BIT=4: all outputs take their reset values; `uart_tx_out` stays 1 for 100 cycles with no writes.
- Write 0xA5 once → line 1 until edge N+1, then 4 cycles 0, bits 1,0,1,0,0,1,0,1 at 4 cycles each, 4 cycles 1; `tx_idle_out` returns to 1.
- Write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles, FIFO_DEPTH=4 → the first write is popped at once, so all five are accepted. A sixth write while count==4 is dropped and sets `tx_overflow_out`. Frames appear in order, separated by one idle cycle.
- Host offers 0x3C then 0x7E back-to-back → 0x3C presented, `host_ready_out`=0, 0x7E stalls. Pulse `cpu_rden_in` → 0x7E is captured the cycle after the consume.
- Reset pulsed in DATA bit 3 → line high immediately, FIFO empty, no further frame after reset release.
